// File: rtl/midi_learn_frontend.sv
// MIDI footswitch controller front end: input debouncing, learn-mode tracking and MIDI receive/parse.
// Optional MIDI_RUNNING_STATUS_EN: data bytes after a complete channel message reuse the last status.
module midi_learn_frontend #(
  parameter int unsigned DEBOUNCE_CNT = 21,
  parameter int unsigned BAUD_CNT     = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       board_btn,
  input  logic       btn2_pin_1,
  input  logic       btn3_pin_1,
  input  logic       btn4_pin_1,
  input  logic       btn5_pin_1,
  input  logic       btn2_pin_2,
  input  logic       btn3_pin_2,
  input  logic       btn4_pin_2,
  input  logic       btn5_pin_2,
  input  logic       midi_rx,
  output logic       save_mode,
  output logic [2:0] btn_index,
  output logic       cmd_pending,
  output logic [7:0] status,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [1:0] bytes_cnt,
  output logic       rx_err
);

  localparam int unsigned NDEB = 5;
  localparam int unsigned BCW  = $clog2(BAUD_CNT);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(BAUD_CNT - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(BAUD_CNT / 2 - 1);
  // {board_btn, pin_2[3:0], pin_1[3:0]} at rest
  localparam logic [8:0] PIN_IDLE = 9'h10F;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [8:0] pin_s1, pin_s2;
  logic       rx_s1, rx_s2, rx_s3;
  logic [3:0] sw_raw;
  logic [NDEB-1:0] deb_lvl, deb_prev, deb_in_c, press_c;
  logic [DEBOUNCE_CNT-1:0] deb_cnt [NDEB];

  rx_state_t  rx_state, rx_state_n;
  logic [BCW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic       byte_vld_c, frame_err_c;

  logic [7:0] ps_status, ps_d1;
  logic       ps_need2, ps_active, ps_got1;
  logic [3:0] sw_edge_c;
  logic [2:0] idx_c;
  logic       assign_ok_c;

  // Two-stage synchronizers for every asynchronous input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pin_s1 <= PIN_IDLE;
      pin_s2 <= PIN_IDLE;
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_s3  <= 1'b1;
    end else begin
      pin_s1 <= {board_btn, btn5_pin_2, btn4_pin_2, btn3_pin_2, btn2_pin_2,
                 btn5_pin_1, btn4_pin_1, btn3_pin_1, btn2_pin_1};
      pin_s2 <= pin_s1;
      rx_s1  <= midi_rx;
      rx_s2  <= rx_s1;
      rx_s3  <= rx_s2;
    end
  end

  // Footswitch contact decode; contradictory contact pairs hold the last state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_raw <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!pin_s2[i] && pin_s2[i+4])      sw_raw[i] <= 1'b1;
        else if (pin_s2[i] && !pin_s2[i+4]) sw_raw[i] <= 1'b0;
      end
    end
  end

  assign deb_in_c = {sw_raw, ~pin_s2[8]};
  assign press_c  = deb_lvl & ~deb_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_lvl  <= '0;
      deb_prev <= '0;
      for (int i = 0; i < NDEB; i++) deb_cnt[i] <= '0;
    end else begin
      deb_prev <= deb_lvl;
      for (int i = 0; i < NDEB; i++) begin
        if (deb_in_c[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == '1) begin
          deb_lvl[i] <= deb_in_c[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEBOUNCE_CNT'(1);
        end
      end
    end
  end

  // UART receiver state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + BCW'(1);
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    byte_vld_c  = 1'b0;
    frame_err_c = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_s3 && !rx_s2) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n    = '0;
          rx_state_n  = RX_IDLE;
          byte_vld_c  = rx_s2;
          frame_err_c = !rx_s2;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Lowest-numbered footswitch wins on simultaneous press edges
  assign sw_edge_c = press_c[4:1];
  always_comb begin
    idx_c = '0;
    for (int i = 3; i >= 0; i--) begin
      if (sw_edge_c[i]) idx_c = 3'(i + 1);
    end
  end
  assign assign_ok_c = (|sw_edge_c) && (!save_mode || cmd_pending);

  // Learn mode, button reporting and MIDI message parser; completion overrides assignment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      save_mode   <= 1'b0;
      btn_index   <= '0;
      cmd_pending <= 1'b0;
      status      <= '0;
      data1       <= '0;
      data2       <= '0;
      bytes_cnt   <= '0;
      rx_err      <= 1'b0;
      ps_status   <= '0;
      ps_d1       <= '0;
      ps_need2    <= 1'b0;
      ps_active   <= 1'b0;
      ps_got1     <= 1'b0;
    end else begin
      btn_index <= assign_ok_c ? idx_c : 3'd0;
      rx_err    <= frame_err_c;
      if (press_c[0]) save_mode <= ~save_mode;
      if (assign_ok_c && save_mode) cmd_pending <= 1'b0;
      if (frame_err_c) begin
        ps_active <= 1'b0;
        ps_got1   <= 1'b0;
      end else if (byte_vld_c) begin
        if (rx_shift[7]) begin
          if (rx_shift[7:4] == 4'hF) begin
            if (!rx_shift[3]) begin
              ps_active <= 1'b0;
              ps_got1   <= 1'b0;
            end
          end else begin
            ps_status   <= rx_shift;
            ps_need2    <= (rx_shift[7:5] != 3'b110);
            ps_active   <= 1'b1;
            ps_got1     <= 1'b0;
            cmd_pending <= 1'b0;
          end
        end else if (ps_active) begin
          if (ps_need2 && !ps_got1) begin
            ps_d1   <= rx_shift;
            ps_got1 <= 1'b1;
          end else begin
            status      <= ps_status;
            data1       <= ps_need2 ? ps_d1 : rx_shift;
            data2       <= ps_need2 ? rx_shift : 8'h00;
            bytes_cnt   <= ps_need2 ? 2'd3 : 2'd2;
            cmd_pending <= 1'b1;
            ps_got1     <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
            ps_active   <= 1'b1;
`else
            ps_active   <= 1'b0;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_learn_frontend.sv
// Directed bench for midi_learn_frontend with short debounce and baud periods.
module tb_midi_learn_frontend;

  localparam int unsigned DEB  = 4;
  localparam int unsigned BAUD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       board_btn;
  logic [3:0] sw_p1, sw_p2;
  logic       midi_rx;
  logic       save_mode, cmd_pending, rx_err;
  logic [2:0] btn_index;
  logic [7:0] status, data1, data2;
  logic [1:0] bytes_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int pulse_cnt = 0;
  int err_cnt   = 0;
  logic [2:0] last_idx = '0;

  midi_learn_frontend #(.DEBOUNCE_CNT(DEB), .BAUD_CNT(BAUD)) dut (
    .clk(clk), .rst(rst), .board_btn(board_btn),
    .btn2_pin_1(sw_p1[0]), .btn3_pin_1(sw_p1[1]), .btn4_pin_1(sw_p1[2]), .btn5_pin_1(sw_p1[3]),
    .btn2_pin_2(sw_p2[0]), .btn3_pin_2(sw_p2[1]), .btn4_pin_2(sw_p2[2]), .btn5_pin_2(sw_p2[3]),
    .midi_rx(midi_rx), .save_mode(save_mode), .btn_index(btn_index),
    .cmd_pending(cmd_pending), .status(status), .data1(data1), .data2(data2),
    .bytes_cnt(bytes_cnt), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && btn_index != 3'd0) begin
      pulse_cnt++;
      last_idx = btn_index;
    end
    if (rst && rx_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sw(input int i, input logic pressed);
    sw_p1[i] = ~pressed;
    sw_p2[i] = pressed;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    midi_rx = 1'b0;
    tick(BAUD);
    for (int k = 0; k < 8; k++) begin
      midi_rx = b[k];
      tick(BAUD);
    end
    midi_rx = stop_bit;
    tick(BAUD);
    midi_rx = 1'b1;
    if (!stop_bit) tick(BAUD);
  endtask

  task automatic press_board();
    board_btn = 1'b0;
    tick(40);
    board_btn = 1'b1;
    tick(40);
  endtask

  task automatic press_sw(input int i);
    set_sw(i, 1'b1);
    tick(40);
    set_sw(i, 1'b0);
    tick(40);
  endtask

  task automatic check_msg(input string tag, input logic [7:0] s, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [1:0] n);
    check({tag, "_pend"}, 32'(cmd_pending), 32'd1);
    check({tag, "_status"}, 32'(status), 32'(s));
    check({tag, "_data1"}, 32'(data1), 32'(d1));
    check({tag, "_data2"}, 32'(data2), 32'(d2));
    check({tag, "_bytes"}, 32'(bytes_cnt), 32'(n));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_save"}, 32'(save_mode), 32'd0);
    check({tag, "_idx"}, 32'(btn_index), 32'd0);
    check({tag, "_pend"}, 32'(cmd_pending), 32'd0);
    check({tag, "_outs"}, {status, data1, data2, 5'd0, bytes_cnt, rx_err}, 32'd0);
  endtask

  int p0;

  initial begin
    rst = 1'b0;
    board_btn = 1'b1;
    sw_p1 = 4'hF;
    sw_p2 = 4'h0;
    midi_rx = 1'b1;
    tick(3);
    check_zero("reset");
    rst = 1'b1;
    tick(5);

    // Channel messages, 3-byte then 2-byte
    send_byte(8'hB0, 1'b1); send_byte(8'h2E, 1'b1); send_byte(8'h7F, 1'b1);
    tick(4);
    check_msg("cc", 8'hB0, 8'h2E, 8'h7F, 2'd3);
    send_byte(8'hC0, 1'b1); send_byte(8'h42, 1'b1);
    tick(4);
    check_msg("pc", 8'hC0, 8'h42, 8'h00, 2'd2);

    // Framing error resets the parser; the stray data byte is ignored
    send_byte(8'hB0, 1'b1); send_byte(8'h2E, 1'b0); send_byte(8'h7F, 1'b1);
    tick(4);
    check("ferr_pulses", 32'(err_cnt), 32'd1);
    check("ferr_pend", 32'(cmd_pending), 32'd0);
    // Realtime byte inside a message
    send_byte(8'hB1, 1'b1); send_byte(8'hF8, 1'b1); send_byte(8'h20, 1'b1); send_byte(8'h05, 1'b1);
    tick(4);
    check_msg("rt", 8'hB1, 8'h20, 8'h05, 2'd3);

    // Debounce: 5-clock bounce on btn3, then held
    p0 = pulse_cnt;
    for (int k = 0; k < 5; k++) begin
      set_sw(1, (k % 2) == 0);
      tick(1);
    end
    tick(10);
    check("bounce_nopulse", 32'(pulse_cnt), 32'(p0));
    tick(30);
    check("deb_one_pulse", 32'(pulse_cnt), 32'(p0 + 1));
    check("deb_idx", 32'(last_idx), 32'd2);
    set_sw(1, 1'b0);
    tick(40);
    sw_p1[1] = 1'b1; sw_p2[1] = 1'b1;
    tick(40);
    sw_p1[1] = 1'b0; sw_p2[1] = 1'b0;
    tick(40);
    set_sw(1, 1'b0);
    tick(40);
    check("invalid_hold", 32'(pulse_cnt), 32'(p0 + 1));

    // Simultaneous presses on btn2 and btn4
    set_sw(0, 1'b1); set_sw(2, 1'b1);
    tick(40);
    set_sw(0, 1'b0); set_sw(2, 1'b0);
    tick(40);
    check("simul_cnt", 32'(pulse_cnt), 32'(p0 + 2));
    check("simul_idx", 32'(last_idx), 32'd1);

    // Learn mode
    press_board();
    check("learn_on", 32'(save_mode), 32'd1);
    send_byte(8'hB2, 1'b1);
    tick(4);
    check("new_status_clr", 32'(cmd_pending), 32'd0);
    p0 = pulse_cnt;
    press_sw(0);
    check("learn_nopend", 32'(pulse_cnt), 32'(p0));
    send_byte(8'hC0, 1'b1); send_byte(8'h43, 1'b1);
    tick(4);
    check_msg("learn_msg", 8'hC0, 8'h43, 8'h00, 2'd2);
    press_sw(0);
    check("learn_pulse", 32'(pulse_cnt), 32'(p0 + 1));
    check("learn_idx", 32'(last_idx), 32'd1);
    check("learn_assigned", 32'(cmd_pending), 32'd0);
    check("learn_hold", {16'd0, status, data1}, 32'h0000C043);
    press_board();
    check("learn_off", 32'(save_mode), 32'd0);

    // Running status
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h40, 1'b1);
    send_byte(8'h3E, 1'b1); send_byte(8'h40, 1'b1);
    tick(4);
`ifdef MIDI_RUNNING_STATUS_EN
    check_msg("runst", 8'h90, 8'h3E, 8'h40, 2'd3);
`else
    check_msg("runst", 8'h90, 8'h3C, 8'h40, 2'd3);
`endif

    // Reset in the middle of a frame
    press_board();
    check("pre_rst_save", 32'(save_mode), 32'd1);
    midi_rx = 1'b0;
    tick(BAUD * 3);
    #2 rst = 1'b0;
    #1 check_zero("midrst");
    midi_rx = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(4);
    send_byte(8'hC5, 1'b1); send_byte(8'h11, 1'b1);
    tick(4);
    check_msg("post_rst", 8'hC5, 8'h11, 8'h00, 2'd2);
    check("total_ferr", 32'(err_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
